// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle logic/arith/compare ops plus iterative MUL/DIVU/REMU
//
// Purpose:
//   Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, MIN, MAX) finish one
//   cycle after start. MUL runs shift-add and DIVU/REMU run restoring
//   division, one bit per cycle over N cycles. The result w is registered
//   and held until the next operation completes.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request; op/a/b sampled when start=1 and the unit is idle
//   op    - operation select (4 bits)
//   a, b  - operands (N bits)
//   busy  - high while an iterative op is in progress
//   done  - one-cycle pulse when w/zero/neg have just been updated
//   w     - registered result
//   zero  - w == 0
//   neg   - w[N-1]

module alu_multicycle #(
   parameter  int N  = 32,
   localparam int CW = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] w,
   output logic         zero,
   output logic         neg
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_MIN  = 4'b0110;
   localparam logic [3:0] OP_MAX  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  w_q, w_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // multiply datapath
   logic [N-1:0]  mcand_q, mcand_d;
   logic [N-1:0]  mplier_q, mplier_d;
   logic [N-1:0]  acc_q, acc_d;

   // divide datapath
   logic [N-1:0]  divisor_q, divisor_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  quo_q, quo_d;
   logic          is_rem_q, is_rem_d;

   logic          slt;
   logic [N-1:0]  acc_next;
   logic [N:0]    div_shifted;
   logic [N:0]    div_diff;
   logic          div_ge;
   logic [N-1:0]  rem_next;
   logic [N-1:0]  quo_next;

   assign slt      = $signed(a) < $signed(b);
   assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // The shifted remainder needs N+1 bits. Because rem_q < divisor, a
   // non-negative difference always fits in N bits, so the top bit of the
   // N+1-bit difference is a clean borrow flag.
   assign div_shifted = {rem_q, quo_q[N-1]};
   assign div_diff    = div_shifted - {1'b0, divisor_q};
   assign div_ge      = ~div_diff[N];
   assign rem_next    = div_ge ? div_diff[N-1:0] : div_shifted[N-1:0];
   assign quo_next    = {quo_q[N-2:0], div_ge};

   always_comb begin
      state_d   = state_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      divisor_d = divisor_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      is_rem_d  = is_rem_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FIN;
               case (op)
                  OP_ADD:  w_d = a + b;
                  OP_SUB:  w_d = a - b;
                  OP_AND:  w_d = a & b;
                  OP_OR:   w_d = a | b;
                  OP_XOR:  w_d = a ^ b;
                  OP_SLT:  w_d = {{(N-1){1'b0}}, slt};
                  OP_MIN:  w_d = slt ? a : b;
                  OP_MAX:  w_d = slt ? b : a;
                  OP_MUL: begin
                     mcand_d  = a;
                     mplier_d = b;
                     acc_d    = '0;
                     cnt_d    = '0;
                     state_d  = S_MUL;
                  end
                  OP_DIVU, OP_REMU: begin
                     if (b == '0) begin
                        // divide by zero short-circuits with no iteration
                        w_d = (op == OP_DIVU) ? '1 : a;
                     end else begin
                        divisor_d = b;
                        quo_d     = a;
                        rem_d     = '0;
                        cnt_d     = '0;
                        is_rem_d  = (op == OP_REMU);
                        state_d   = S_DIV;
                     end
                  end
                  default: w_d = '0;
               endcase
            end
         end

         S_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == LAST_CNT) begin
               w_d     = acc_next;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DIV: begin
            rem_d = rem_next;
            quo_d = quo_next;
            if (cnt_q == LAST_CNT) begin
               w_d     = is_rem_q ? rem_next : quo_next;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_FIN: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         w_q       <= '0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         is_rem_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         divisor_q <= divisor_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         is_rem_q  <= is_rem_d;
      end
   end

   assign busy = (state_q == S_MUL) || (state_q == S_DIV);
   assign done = (state_q == S_FIN);
   assign w    = w_q;
   assign zero = (w_q == '0);
   assign neg  = w_q[N-1];

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle (N=32 and N=8)

module tb_alu_multicycle;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b, w;
   logic        busy, done, zero, neg;

   logic        start8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, w8;
   logic        busy8, done8, zero8, neg8;

   int n_checks = 0;
   int n_errors = 0;

   alu_multicycle #(.N(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .w(w), .zero(zero), .neg(neg)
   );

   alu_multicycle #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .w(w8), .zero(zero8), .neg(neg8)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_w;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
      end
   endtask

   function automatic void add(input string nm, input logic [3:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] e, input int l);
      vec_t v;
      v.name = nm; v.op = o; v.a = x; v.b = y; v.exp_w = e; v.exp_lat = l;
      vecs.push_back(v);
   endfunction

   // Issues one request from idle and waits for done. lat counts cycles from
   // the start edge to the sample where done is seen.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] got, output int lat, output int nbusy);
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; nbusy = 0;
      while (!done && lat < 200) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy) nbusy++;
      got = w;
   endtask

   task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] got, output int lat);
      @(posedge clk); #1;
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      got = w8;
   endtask

   initial begin
      logic [31:0] got;
      logic [7:0]  got8;
      int          lat, nbusy;
      logic        seen, ok;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

      add("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
      add("sub_eq",   4'b0001, 32'd5,         32'd5,         32'h0,         1);
      add("and",      4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
      add("or",       4'b0011, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1);
      add("xor",      4'b0100, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1);
      add("slt_t",    4'b0101, 32'hFFFF_FFFF, 32'h1,         32'h1,         1);
      add("slt_f",    4'b0101, 32'h1,         32'hFFFF_FFFF, 32'h0,         1);
      add("slt_eq",   4'b0101, 32'd3,         32'd3,         32'h0,         1);
      add("min",      4'b0110, 32'hFFFF_FFFC, 32'd3,         32'hFFFF_FFFC, 1);
      add("max",      4'b0111, 32'hFFFF_FFFC, 32'd3,         32'd3,         1);
      add("min_eq",   4'b0110, 32'd5,         32'd5,         32'd5,         1);
      add("max_eq",   4'b0111, 32'd9,         32'd9,         32'd9,         1);
      add("mul",      4'b1000, 32'd12345,     32'd6789,      32'd83810205,  33);
      add("mul_ones", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33);
      add("mul_wrap", 4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0,         33);
      add("divu",     4'b1001, 32'd100,       32'd7,         32'd14,        33);
      add("remu",     4'b1010, 32'd100,       32'd7,         32'd2,         33);
      add("divu_z",   4'b1001, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      add("remu_z",   4'b1010, 32'd5,         32'd0,         32'd5,         1);
      add("divu_max", 4'b1001, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
      add("remu_max", 4'b1010, 32'hFFFF_FFFF, 32'd10,        32'd5,         33);
      add("divu_sm",  4'b1001, 32'd3,         32'd5,         32'd0,         33);
      add("illegal",  4'b1100, 32'd7,         32'd8,         32'h0,         1);
      add("illegal_f",4'b1111, 32'd7,         32'd8,         32'h0,         1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_w",    w,             32'd0);
      check("rst_zero", {31'd0, zero}, 32'd1);
      check("rst_neg",  {31'd0, neg},  32'd0);
      check("rst_w8",   {24'd0, w8},   32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         logic [31:0] ew;
         ew = vecs[i].exp_w;
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat, nbusy);
         check({vecs[i].name, " w"},    got,               ew);
         check({vecs[i].name, " lat"},  lat,               vecs[i].exp_lat);
         check({vecs[i].name, " busy"}, nbusy,             vecs[i].exp_lat - 1);
         check({vecs[i].name, " zero"}, {31'd0, zero},     {31'd0, ew == 32'd0});
         check({vecs[i].name, " neg"},  {31'd0, neg},      {31'd0, ew[31]});
      end

      // reset in the 3rd busy cycle of a MUL aborts it
      run_op(4'b0000, 32'd1, 32'd1, got, lat, nbusy);
      check("pre_rst_add", got, 32'd2);
      @(posedge clk); #1;
      start = 1'b1; op = 4'b1000; a = 32'd7; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_w",    w,             32'd0);
      check("abort_zero", {31'd0, zero}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", {31'd0, seen}, 32'd0);
      run_op(4'b0000, 32'd2, 32'd3, got, lat, nbusy);
      check("post_rst_add", got, 32'd5);
      check("post_rst_lat", lat, 1);

      // start held with ADD throughout a DIVU is ignored until idle
      @(posedge clk); #1;
      start = 1'b1; op = 4'b1001; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      op = 4'b0000; a = 32'd1; b = 32'd1;
      ok = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         if (!busy || done || w !== 32'd5) ok = 1'b0;
         a = i;
         @(posedge clk); #1;
      end
      a = 32'd1;
      check("hs_hold",    {31'd0, ok},   32'd1);
      check("hs_done",    {31'd0, done}, 32'd1);
      check("hs_divu_w",  w,             32'd14);
      @(posedge clk); #1;
      check("hs_fin_gap", {31'd0, done}, 32'd0);
      check("hs_gap_w",   w,             32'd14);
      @(posedge clk); #1;
      start = 1'b0;
      check("hs_add_done", {31'd0, done}, 32'd1);
      check("hs_add_w",    w,             32'd2);

      // N=8 instance
      run8(4'b1000, 8'd15, 8'd17, got8, lat);
      check("n8_mul_w",   {24'd0, got8},  32'hFF);
      check("n8_mul_lat", lat,            9);
      check("n8_mul_neg", {31'd0, neg8},  32'd1);
      run8(4'b1000, 8'd16, 8'd16, got8, lat);
      check("n8_mulz_w",  {24'd0, got8},  32'h0);
      check("n8_mulz_z",  {31'd0, zero8}, 32'd1);
      run8(4'b1001, 8'd200, 8'd7, got8, lat);
      check("n8_divu_w",  {24'd0, got8},  32'd28);
      check("n8_divu_lat", lat,           9);
      run8(4'b1010, 8'd200, 8'd7, got8, lat);
      check("n8_remu_w",  {24'd0, got8},  32'd4);
      run8(4'b0000, 8'd200, 8'd100, got8, lat);
      check("n8_add_w",   {24'd0, got8},  32'd44);
      check("n8_add_lat", lat,            1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
